// File: rtl/pcm_to_i2s_tx_if.sv
// ---------------------------------------------------------------------------
// pcm_to_i2s_tx_if
// Stereo PCM sample-pair handshake into the I2S transmitter.
//
// Handshake: a pair (in_left, in_right) transfers on every rising clk edge
// where in_valid && in_ready are both high. The master holds in_valid and
// the data stable until the transfer happens. in_ready may be asserted
// without in_valid, and it never depends combinationally on in_valid.
// ---------------------------------------------------------------------------
interface pcm_to_i2s_tx_if #(
  parameter int NUMBER_OF_BITS = 8
) ();

  logic                      in_valid;
  logic                      in_ready;
  logic [NUMBER_OF_BITS-1:0] in_left;
  logic [NUMBER_OF_BITS-1:0] in_right;

  // Upstream producer (beamformer sum stage or testbench driver)
  modport master (
    output in_valid,
    output in_left,
    output in_right,
    input  in_ready
  );

  // The I2S transmitter
  modport slave (
    input  in_valid,
    input  in_left,
    input  in_right,
    output in_ready
  );

endinterface

// File: rtl/pcm_to_i2s_tx.sv
// ---------------------------------------------------------------------------
// pcm_to_i2s_tx
// Philips-I2S master transmitter. Stereo PCM pairs arrive over a
// valid/ready handshake into a 2-entry FIFO; one pair is loaded per frame
// and shifted out MSB-first with the one-bit delay after each ws edge.
//
// Optional feature macro: I2S_TX_UNDERRUN_CNT_EN adds an 8-bit saturating
// underrun_count output. Without it the module has no counter at all.
// ---------------------------------------------------------------------------
module pcm_to_i2s_tx #(
  parameter int NUMBER_OF_BITS = 8,   // PCM bits per channel
  parameter int SLOT_BITS      = 16,  // bit periods per channel slot (>= NUMBER_OF_BITS+1)
  parameter int BCLK_DIV       = 2    // clk cycles per sck half-period (>= 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ena,
  pcm_to_i2s_tx_if.slave pcm,
  output logic           sck,
  output logic           ws,
  output logic           sd,
  output logic           underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
  ,
  output logic [7:0]     underrun_count
`endif
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int CW         = $clog2(FRAME_BITS);
  localparam int DW         = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_BITS - 1);
  localparam logic [CW-1:0] SLOT_LEN = CW'(SLOT_BITS);
  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);

  // ------------------------------------------------------------------------
  // Bit-clock timing state
  // ------------------------------------------------------------------------
  logic [DW-1:0] div_cnt;
  logic [CW-1:0] bit_cnt;      // position within the frame, 0..2*SLOT_BITS-1
  logic [CW-1:0] nxt_bit_cnt;
  logic          sck_toggle;   // sck changes level on this clk
  logic          sck_fall;     // the toggle is a high->low transition
  logic          frame_load;   // the fall that starts a new frame

  // ------------------------------------------------------------------------
  // FIFO state
  // ------------------------------------------------------------------------
  logic [NUMBER_OF_BITS-1:0] fifo_l [2];
  logic [NUMBER_OF_BITS-1:0] fifo_r [2];
  logic                      wr_ptr;
  logic                      rd_ptr;
  logic [1:0]                count;
  logic [1:0]                count_nxt;
  logic                      in_ready_q;
  logic                      push;
  logic                      pop;

  // ------------------------------------------------------------------------
  // Frame registers: the pair currently on the wire
  // ------------------------------------------------------------------------
  logic [NUMBER_OF_BITS-1:0] left_q;
  logic [NUMBER_OF_BITS-1:0] right_q;

  // Next serial bit, computed from the bit position entered at the fall
  logic [CW-1:0]             slot_pos;
  logic [NUMBER_OF_BITS-1:0] cur_sample;
  logic                      sd_nxt;

  // Divider edge and frame position decode
  always_comb begin
    sck_toggle  = ena && (div_cnt == DIV_LAST);
    sck_fall    = sck_toggle && sck;
    nxt_bit_cnt = (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
    frame_load  = sck_fall && (nxt_bit_cnt == '0);
  end

  // Select sample bit for the slot position being entered (0 = delay bit)
  always_comb begin
    slot_pos   = (nxt_bit_cnt >= SLOT_LEN) ? nxt_bit_cnt - SLOT_LEN : nxt_bit_cnt;
    cur_sample = (nxt_bit_cnt >= SLOT_LEN) ? right_q : left_q;
    sd_nxt     = 1'b0;
    // Slot position k in 1..NUMBER_OF_BITS carries sample bit NUMBER_OF_BITS-k;
    // position 0 and the tail of the slot stay zero.
    for (int i = 0; i < NUMBER_OF_BITS; i++) begin
      if (int'(slot_pos) == NUMBER_OF_BITS - i) begin
        sd_nxt = cur_sample[i];
      end
    end
  end

  // Divider, sck/ws/sd generation and underrun pulse; everything holds while ena is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      bit_cnt  <= LAST_BIT;
      sck      <= 1'b0;
      ws       <= 1'b1;
      sd       <= 1'b0;
      underrun <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (ena) begin
        div_cnt <= sck_toggle ? '0 : div_cnt + 1'b1;
        if (sck_toggle) begin
          sck <= ~sck;
        end
        if (sck_fall) begin
          bit_cnt <= nxt_bit_cnt;
          ws      <= (nxt_bit_cnt >= SLOT_LEN);
          sd      <= sd_nxt;
        end
        if (frame_load) begin
          underrun <= (count == 2'd0);
        end
      end
    end
  end

  // Frame registers: take the FIFO head at frame start, or silence if empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left_q  <= '0;
      right_q <= '0;
    end else if (frame_load) begin
      if (pop) begin
        left_q  <= fifo_l[rd_ptr];
        right_q <= fifo_r[rd_ptr];
      end else begin
        left_q  <= '0;
        right_q <= '0;
      end
    end
  end

  // ------------------------------------------------------------------------
  // FIFO control. The pop decision uses occupancy before this cycle's push,
  // so a pair arriving into an empty FIFO on the load cycle waits a frame.
  // ------------------------------------------------------------------------
  always_comb begin
    push      = pcm.in_valid && in_ready_q;
    pop       = frame_load && (count != 2'd0);
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 2'd1;
      2'b01:   count_nxt = count - 2'd1;
      default: count_nxt = count;
    endcase
  end

  // Occupancy, pointers and registered ready (low whenever the FIFO is full)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= 2'd0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      count      <= count_nxt;
      in_ready_q <= (count_nxt != 2'd2);
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
    end
  end

  // FIFO storage; contents are don't-care while the occupancy says empty
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_l[wr_ptr] <= pcm.in_left;
      fifo_r[wr_ptr] <= pcm.in_right;
    end
  end

  assign pcm.in_ready = in_ready_q;

`ifdef I2S_TX_UNDERRUN_CNT_EN
  // Saturating count of underrun pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_count <= 8'd0;
    end else if (underrun && (underrun_count != 8'hFF)) begin
      underrun_count <= underrun_count + 8'd1;
    end
  end
`endif

endmodule
